stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control FSM and BCD time counter for the stopwatch. Consumes the 10 ms tick from the clock divider and the debounced front-panel buttons, sequences run/pause/lap/clear, and presents a six-digit MM:SS.cc value to the display multiplexer. Asserts a one-cycle `tb_sync` pulse on every start from zero so the divider restarts its phase and the first centisecond is a full 10 ms.

## Interface
- `MIN_MOD`, default 60: minutes modulus. Legal range 2..100; the count wraps after `MIN_MOD`-1 minutes.

- `clk`  in  1  system clock (100 MHz)
- `reset`  in  1  synchronous, active-high; clears all state
- `tick_10ms`  in  1  one-cycle pulse from the divider, every 10 ms
- `btn_ss`  in  1  start/stop button; debounced, synchronous level
- `btn_lap`  in  1  lap button; debounced, synchronous level
- `btn_clr`  in  1  clear button; debounced, synchronous level
- `disp_bcd`  out  24  {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, 4-bit BCD each
- `running`  out  1  high in RUNNING or LAP
- `lap_hold`  out  1  high in LAP, when the display is frozen
- `overflow`  out  1  sticky; set on wrap past max time
- `tb_sync`  out  1  one-cycle pulse that resets the divider phase

## Operation
- Edge detect: each button is registered once (`*_q`). Event = `btn & ~btn_q`. Held buttons produce exactly one event.
- Same-cycle priority: ss > lap > clr. Lower-priority events in that cycle are dropped.
- States: IDLE (count zero, stopped), RUNNING, LAP (counting, display frozen), PAUSED.
  - IDLE: ss -> RUNNING and pulse `tb_sync`. lap and clr are ignored.
  - RUNNING: ss -> PAUSED. lap -> LAP and capture the current count into `lap_reg`. clr is ignored.
  - LAP: lap -> RUNNING, releasing the display. ss -> PAUSED, with the display returning to the live count. clr is ignored.
  - PAUSED: ss -> RUNNING, with no `tb_sync`. clr -> IDLE, zeroing the count and clearing `overflow`. lap is ignored.
- Counting: on `tick_10ms` while the current (pre-transition) state is RUNNING or LAP, increment the BCD chain.
  - cs_o 0-9 carries into cs_t 0-9.
  - cs_t carries into sec_o 0-9, then sec_t 0-5.
  - sec_t carries into the minute pair, which is modulo `MIN_MOD` (BCD).
  - No digit ever holds a value above 9. sec_t never exceeds 5.
- Wrap: incrementing from (`MIN_MOD`-1):59.99 gives 00:00.00 and sets `overflow`. Counting continues.
- `disp_bcd` = `lap_hold` ? `lap_reg` : `count`. This is a mux of registers only.
- A lap capture takes the count value before the same-edge increment.

## Timing
- Reset values: `disp_bcd`=0, `count`=0, `lap_reg`=0, state IDLE, `running`=0, `lap_hold`=0, `overflow`=0, `tb_sync`=0, all `*_q`=0.
- Reset has priority over every other input in the same cycle, including mid-run and mid-lap.
- Button latency: if a button is first high at edge N, the state, `running`, `lap_hold` and `tb_sync` change at edge N.
- `tb_sync` is high for exactly the cycle after the IDLE->RUNNING edge.
- The divider restarts on `tb_sync`, so the first tick arrives about 10 ms later.
- A tick coinciding with a ss event in RUNNING is counted; the state change applies to the next tick.
- A tick coinciding with a ss event in PAUSED is not counted.
- Tick-to-display latency: `count` and `disp_bcd` update at the same edge as the sampled tick.
- A `tick_10ms` held high for k cycles counts k times. The divider guarantees a 1-cycle pulse; the bench checks the k-count behaviour anyway.

## Test plan
- Reset, ss pulse, 150 ticks -> `disp_bcd`=24'h000150, `running`=1, exactly one `tb_sync` pulse.
- Run to 00:59.99, then 1 tick -> 24'h010000. Preload to 59:59.99 and tick -> 24'h000000 with `overflow`=1; clr from PAUSED -> `overflow`=0.
- RUNNING at 00:02.00; lap; 50 ticks -> `disp_bcd` stays 24'h000200 with `lap_hold`=1; lap again -> 24'h000250.
- ss and tick in the same cycle at 00:00.07 -> PAUSED, count 00:00.08. Further ticks leave it unchanged. ss again -> RUNNING with no `tb_sync`.
- ss+lap+clr rising together in RUNNING -> PAUSED only, `lap_reg` unchanged. Holding btn_ss high for 1000 cycles -> one transition.
- Reset asserted in LAP with a tick in the same cycle -> all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, run/lap/pause sequencing and a
// six-digit BCD MM:SS.cc time counter feeding the display multiplexer.
// Emits a one-cycle tb_sync pulse on each start from zero so the 10 ms
// divider restarts its phase.
module stopwatch_ctrl #(
    parameter int unsigned MIN_MOD = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_10ms,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic        btn_clr,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_hold,
    output logic        overflow,
    output logic        tb_sync
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2,
        ST_PAUSED  = 2'd3
    } state_t;

    // Highest legal minute value, split into its BCD digits.
    localparam logic [3:0] MAX_MT = 4'((MIN_MOD - 1) / 10);
    localparam logic [3:0] MAX_MO = 4'((MIN_MOD - 1) % 10);

    state_t      state_q;
    logic        btn_ss_q;
    logic        btn_lap_q;
    logic        btn_clr_q;
    logic [23:0] count_q;
    logic [23:0] lap_reg_q;
    logic        running_q;
    logic        lap_hold_q;
    logic        overflow_q;
    logic        tb_sync_q;

    logic        ss_ev_s;
    logic        lap_ev_s;
    logic        clr_ev_s;
    logic [23:0] count_d;
    logic        wrap_d;

    // Rising-edge events; a held button yields one event only.
    always_comb begin
        ss_ev_s  = btn_ss  & ~btn_ss_q;
        lap_ev_s = btn_lap & ~btn_lap_q;
        clr_ev_s = btn_clr & ~btn_clr_q;
    end

    // Incremented BCD count with ripple carries; wrap flags the minute rollover.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (count_q[3:0] != 4'd9) begin
            count_d[3:0] = count_q[3:0] + 4'd1;
        end else begin
            count_d[3:0] = 4'd0;
            if (count_q[7:4] != 4'd9) begin
                count_d[7:4] = count_q[7:4] + 4'd1;
            end else begin
                count_d[7:4] = 4'd0;
                if (count_q[11:8] != 4'd9) begin
                    count_d[11:8] = count_q[11:8] + 4'd1;
                end else begin
                    count_d[11:8] = 4'd0;
                    if (count_q[15:12] != 4'd5) begin
                        count_d[15:12] = count_q[15:12] + 4'd1;
                    end else begin
                        count_d[15:12] = 4'd0;
                        if ((count_q[23:20] == MAX_MT) && (count_q[19:16] == MAX_MO)) begin
                            count_d[23:16] = 8'h00;
                            wrap_d         = 1'b1;
                        end else if (count_q[19:16] != 4'd9) begin
                            count_d[19:16] = count_q[19:16] + 4'd1;
                        end else begin
                            count_d[19:16] = 4'd0;
                            count_d[23:20] = count_q[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Control FSM, time counter, lap capture and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            btn_ss_q   <= 1'b0;
            btn_lap_q  <= 1'b0;
            btn_clr_q  <= 1'b0;
            count_q    <= 24'h000000;
            lap_reg_q  <= 24'h000000;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
            overflow_q <= 1'b0;
            tb_sync_q  <= 1'b0;
        end else begin
            btn_ss_q  <= btn_ss;
            btn_lap_q <= btn_lap;
            btn_clr_q <= btn_clr;
            tb_sync_q <= 1'b0;

            // Counting uses the state before this edge's transition.
            if (tick_10ms && ((state_q == ST_RUNNING) || (state_q == ST_LAP))) begin
                count_q <= count_d;
                if (wrap_d) begin
                    overflow_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (ss_ev_s) begin
                        state_q   <= ST_RUNNING;
                        running_q <= 1'b1;
                        tb_sync_q <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (ss_ev_s) begin
                        state_q   <= ST_PAUSED;
                        running_q <= 1'b0;
                    end else if (lap_ev_s) begin
                        // Capture the value before any same-edge increment.
                        state_q    <= ST_LAP;
                        lap_reg_q  <= count_q;
                        lap_hold_q <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (ss_ev_s) begin
                        state_q    <= ST_PAUSED;
                        running_q  <= 1'b0;
                        lap_hold_q <= 1'b0;
                    end else if (lap_ev_s) begin
                        state_q    <= ST_RUNNING;
                        lap_hold_q <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (ss_ev_s) begin
                        state_q   <= ST_RUNNING;
                        running_q <= 1'b1;
                    end else if (clr_ev_s) begin
                        state_q    <= ST_IDLE;
                        count_q    <= 24'h000000;
                        overflow_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    running_q  <= 1'b0;
                    lap_hold_q <= 1'b0;
                end
            endcase
        end
    end

    assign disp_bcd = lap_hold_q ? lap_reg_q : count_q;
    assign running  = running_q;
    assign lap_hold = lap_hold_q;
    assign overflow = overflow_q;
    assign tb_sync  = tb_sync_q;

endmodule
